priority_encoder_42: RTL and testbench
======================================

// Module: priority_encoder_42
// PURPOSE
//   4-to-2 priority encoder with registered outputs.
//   Reports the index of the highest-priority asserted request among i0..i3; i3 has the highest priority.
//   Also flags whether any request is asserted.
//   Used as a request-to-index stage in front of simple grant/select logic.
// PARAMETERS
//   none (fixed 4 inputs, 2-bit code)
// PORTS
//   clk    in   1  rising-edge clock; the only clock
//   rst    in   1  reset, asynchronous, active-high
//   i0     in   1  request 0 (lowest priority)
//   i1     in   1  request 1
//   i2     in   1  request 2
//   i3     in   1  request 3 (highest priority)
//   y0     out  1  encoded index, bit 0 (registered)
//   y1     out  1  encoded index, bit 1 (registered)
//   valid  out  1  1 = at least one request was asserted (registered)
// BEHAVIOUR
//   Reset:
//   - While rst=1, y1=0, y0=0, valid=0 immediately, independent of clk.
//   - Outputs hold these values until the first rising clk edge after rst falls.
//   Encoding (combinational, evaluated on the current inputs):
//   - i3=1           -> {y1,y0}=2'b11
//   - i3=0, i2=1     -> 2'b10
//   - i3=0, i2=0, i1=1 -> 2'b01
//   - only i0=1      -> 2'b00
//   - valid_next = i0|i1|i2|i3
//   - All inputs 0 -> {y1,y0}=2'b00, valid=0; valid disambiguates this from "i0 only".
//   Timing:
//   - The encoded result is captured on each rising clk edge and appears on the outputs the same edge.
//   - Latency is 1 cycle from input sample to output.
//   - Outputs are stable between edges.
//   - Lower-priority inputs are don't-care whenever a higher-priority input is 1; any mix of simultaneous requests resolves to the highest index.
//   Reset behaviour:
//   - rst asserting mid-operation clears the outputs at once.
//   - rst deasserting does not itself update the outputs; the next clk edge does.
//   - No handshake, no internal state beyond the output registers.
// TESTING
//   1. rst=1 with i3..i0=1111 and clk running -> y1y0=00, valid=0 throughout.
//   2. After reset, walk all 16 input combinations, one per cycle.
//      - Each cycle after the edge: y1y0 = index of highest set input (e.g. 0101 -> 10, 0011 -> 01).
//      - valid=1 except for 0000.
//   3. i3..i0=0000 -> y1y0=00, valid=0; then 0001 -> y1y0=00, valid=1.
//   4. Latency: change inputs from 0001 to 1000 between edges -> outputs stay 00 until the next rising edge, then read 11.
//   5. Mid-operation reset: outputs at 11/valid=1, pulse rst between edges.
//      - Outputs go to 00/valid=0 without waiting for a clk edge.
//      - They recover on the first edge after rst deasserts.
//   6. Glitch check: toggle i0 while i3=1 -> y1y0 stays 11 every cycle.

Source files
------------

// File: rtl/priority_encoder_42_if.sv
// Request/result bundle for the 4-to-2 priority encoder.
// master drives the requests and reads the encoded result; slave is the encoder side.
interface priority_encoder_42_if;
    logic i0;
    logic i1;
    logic i2;
    logic i3;
    logic y0;
    logic y1;
    logic valid;

    modport master (
        output i0,
        output i1,
        output i2,
        output i3,
        input  y0,
        input  y1,
        input  valid
    );

    modport slave (
        input  i0,
        input  i1,
        input  i2,
        input  i3,
        output y0,
        output y1,
        output valid
    );
endinterface

// File: rtl/priority_encoder_42.sv
// 4-to-2 priority encoder with registered outputs; i3 has the highest priority.
// valid separates "no request" from "only i0 requesting", which share code 2'b00.
module priority_encoder_42 (
    input logic             clk,
    input logic             rst,
    priority_encoder_42_if.slave bus
);

    logic [1:0] code_d;
    logic [1:0] code_q;
    logic       valid_d;
    logic       valid_q;

    // Combinational priority encode of the current requests.
    always_comb begin
        code_d  = 2'b00;
        valid_d = bus.i0 | bus.i1 | bus.i2 | bus.i3;
        if (bus.i3) begin
            code_d = 2'b11;
        end else if (bus.i2) begin
            code_d = 2'b10;
        end else if (bus.i1) begin
            code_d = 2'b01;
        end
    end

    // Output registers; reset clears them immediately, release waits for the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign bus.y0    = code_q[0];
    assign bus.y1    = code_q[1];
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_42.sv
// Directed bench for priority_encoder_42 with a scoreboard queue of expected {valid,y1,y0}.
module tb_priority_encoder_42;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [2:0] exp_q[$];

    priority_encoder_42_if bus ();

    priority_encoder_42 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference encode: scan from the top request down.
    function automatic logic [2:0] model(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) begin
                idx = k[1:0];
                break;
            end
        end
        return {(v != 4'b0000), idx};
    endfunction

    function automatic logic [2:0] observed();
        return {bus.valid, bus.y1, bus.y0};
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed {valid,y1,y0}=%b expected %b", tag, obs, expv);
        end
    endtask

    task automatic set_inputs(input logic [3:0] v);
        bus.i3 = v[3];
        bus.i2 = v[2];
        bus.i1 = v[1];
        bus.i0 = v[0];
    endtask

    // Drive between edges and record the result the next edge must produce.
    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        set_inputs(v);
        exp_q.push_back(model(v));
    endtask

    // Let one rising edge pass, then compare against the oldest expectation.
    task automatic step(input string tag);
        logic [2:0] expv;
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s: scoreboard empty observed=%b", tag, observed());
        end
        if (exp_q.size() != 0) begin
            expv = exp_q.pop_front();
            check(tag, observed(), expv);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_inputs(4'b1111);

        // Reset held with all requests active and clock running.
        #1;
        check("reset_t0", observed(), 3'b000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("reset_hold", observed(), 3'b000);
        end

        // Release reset between edges: outputs wait for the next edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release", observed(), 3'b000);
        exp_q.push_back(model(4'b1111));
        step("first_edge");

        // Walk all request combinations, one per cycle.
        for (int v = 0; v < 16; v++) begin
            drive(v[3:0]);
            step($sformatf("walk_%04b", v[3:0]));
        end

        // No request versus i0-only request.
        drive(4'b0000);
        step("none");
        drive(4'b0001);
        step("i0_only");

        // Latency: input change between edges is not visible until the next edge.
        @(negedge clk);
        set_inputs(4'b1000);
        exp_q.push_back(model(4'b1000));
        #1;
        check("latency_hold", observed(), 3'b100);
        step("latency_edge");

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_clear", observed(), 3'b000);
        #1;
        rst = 1'b0;
        #1;
        check("after_release", observed(), 3'b000);
        exp_q.push_back(model(4'b1000));
        step("recover");

        // i0 toggling under i3 must not disturb the code.
        for (int c = 0; c < 6; c++) begin
            drive({1'b1, 2'b00, c[0]});
            step("glitch_i3");
        end

        // Mixed requests resolve to the highest index.
        drive(4'b0110);
        step("mix_0110");
        drive(4'b1011);
        step("mix_1011");
        drive(4'b0011);
        step("mix_0011");

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
